// File: rtl/pe_array_pipe.sv
// Two-stage, multi-lane polar SC-decoder PE: f (min-sum) or g (add/sub) per vector.
// Define PE_SAT_EN for symmetric saturation on overflow; otherwise results wrap.
module pe_array_pipe #(
  parameter int unsigned LLR_W = 19,
  parameter int unsigned LANES = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES-1:0]       in_u,
  input  logic [LANES*LLR_W-1:0] in_llr_a,
  input  logic [LANES*LLR_W-1:0] in_llr_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LLR_W-1:0] out_llr,
  output logic [TAG_W-1:0]       out_tag,
  output logic [LANES-1:0]       out_ovf,
  output logic                   busy
);

  localparam int unsigned EW = LLR_W + 1;

  logic adv1, adv2;

  logic                       s1_valid_q;
  logic                       s1_mode_q;
  logic [TAG_W-1:0]           s1_tag_q;
  logic [LANES-1:0]           s1_neg_q, s1_neg_d;
  logic [LANES-1:0][EW-1:0]   s1_mag_a_q, s1_mag_a_d;
  logic [LANES-1:0][EW-1:0]   s1_mag_b_q, s1_mag_b_d;
  logic [LANES-1:0][EW-1:0]   s1_sum_q, s1_sum_d;

  logic                       out_valid_q;
  logic [TAG_W-1:0]           out_tag_q;
  logic [LANES-1:0][LLR_W-1:0] out_llr_q, s2_llr_d;
  logic [LANES-1:0]           out_ovf_q, s2_ovf_d;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign busy     = s1_valid_q || out_valid_q;

  assign out_valid = out_valid_q;
  assign out_llr   = out_llr_q;
  assign out_tag   = out_tag_q;
  assign out_ovf   = out_ovf_q;

`ifdef PE_SAT_EN
  localparam logic [LLR_W-1:0] PosMax = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic [LLR_W-1:0] NegMax = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};
  localparam logic [EW-1:0]    MinExt = {2'b11, {(LLR_W-1){1'b0}}};
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [EW-1:0] a_ext, b_ext;
    logic [EW-1:0] min_mag, exact;
    logic          ovf_raw;

    assign a_ext = {in_llr_a[i*LLR_W+LLR_W-1], in_llr_a[i*LLR_W +: LLR_W]};
    assign b_ext = {in_llr_b[i*LLR_W+LLR_W-1], in_llr_b[i*LLR_W +: LLR_W]};

    assign s1_neg_d[i]   = a_ext[EW-1] ^ b_ext[EW-1];
    assign s1_mag_a_d[i] = a_ext[EW-1] ? (~a_ext + 1'b1) : a_ext;
    assign s1_mag_b_d[i] = b_ext[EW-1] ? (~b_ext + 1'b1) : b_ext;
    assign s1_sum_d[i]   = in_u[i] ? (b_ext - a_ext) : (a_ext + b_ext);

    assign min_mag = (s1_mag_a_q[i] < s1_mag_b_q[i]) ? s1_mag_a_q[i] : s1_mag_b_q[i];
    assign exact   = s1_mode_q ? s1_sum_q[i]
                               : (s1_neg_q[i] ? (~min_mag + 1'b1) : min_mag);
    // Exact result fits LLR_W bits iff the two top bits of the EW-bit value agree.
    assign ovf_raw = exact[EW-1] ^ exact[EW-2];

`ifdef PE_SAT_EN
    logic is_min;
    assign is_min      = (exact == MinExt);
    assign s2_llr_d[i] = ovf_raw ? (exact[EW-1] ? NegMax : PosMax)
                                 : (is_min ? NegMax : exact[LLR_W-1:0]);
    assign s2_ovf_d[i] = ovf_raw | is_min;
`else
    assign s2_llr_d[i] = exact[LLR_W-1:0];
    assign s2_ovf_d[i] = ovf_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_tag_q   <= '0;
      s1_neg_q   <= '0;
      s1_mag_a_q <= '0;
      s1_mag_b_q <= '0;
      s1_sum_q   <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q  <= in_mode;
        s1_tag_q   <= in_tag;
        s1_neg_q   <= s1_neg_d;
        s1_mag_a_q <= s1_mag_a_d;
        s1_mag_b_q <= s1_mag_b_d;
        s1_sum_q   <= s1_sum_d;
      end
    end
  end

  // Output data only moves when a real vector arrives, keeping out_* stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_llr_q   <= '0;
      out_ovf_q   <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_tag_q <= s1_tag_q;
        out_llr_q <= s2_llr_d;
        out_ovf_q <= s2_ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_pipe.sv
// Self-checking bench for pe_array_pipe: queue-based behavioural model plus directed literals.
module tb_pe_array_pipe;

  localparam int unsigned LLR_W = 19;
  localparam int unsigned LANES = 8;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned VW    = LANES * LLR_W;
  localparam longint      MAXV  = (longint'(1) << (LLR_W - 1)) - 1;
  localparam longint      MINV  = -(longint'(1) << (LLR_W - 1));

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [LANES-1:0] in_u;
  logic [VW-1:0]    in_llr_a;
  logic [VW-1:0]    in_llr_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [VW-1:0]    out_llr;
  logic [TAG_W-1:0] out_tag;
  logic [LANES-1:0] out_ovf;
  logic             busy;

  typedef struct {
    logic [VW-1:0]    llr;
    logic [LANES-1:0] ovf;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] seen_tags[$];
  int               cyc;
  int               n_checks;
  int               n_pass;

  pe_array_pipe #(
    .LLR_W(LLR_W),
    .LANES(LANES),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_u     (in_u),
    .in_llr_a (in_llr_a),
    .in_llr_b (in_llr_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_llr  (out_llr),
    .out_tag  (out_tag),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic longint lane_val(input logic [VW-1:0] v, input int i);
    return longint'($signed(v[i*LLR_W +: LLR_W]));
  endfunction

  function automatic logic [LLR_W-1:0] lv(input longint x);
    return x[LLR_W-1:0];
  endfunction

  // Exact integer arithmetic, then the overflow policy of the build.
  function automatic void lane_model(input logic mode, input logic u, input longint a,
                                     input longint b, output longint v, output logic ovf);
    longint ma, mb, m, r, w;
    if (!mode) begin
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      m  = (ma < mb) ? ma : mb;
      r  = ((a < 0) != (b < 0)) ? -m : m;
    end else begin
      r = u ? (b - a) : (a + b);
    end
    ovf = (r > MAXV) || (r < MINV);
`ifdef PE_SAT_EN
    if (r > MAXV) v = MAXV;
    else if (r < MINV) v = -MAXV;
    else if (r == MINV) begin
      v   = -MAXV;
      ovf = 1'b1;
    end else v = r;
`else
    w = r & ((longint'(1) << LLR_W) - 1);
    if (w > MAXV) w = w - (longint'(1) << LLR_W);
    v = w;
`endif
  endfunction

  function automatic exp_t model_vec(input logic mode, input logic [LANES-1:0] u,
                                     input logic [VW-1:0] a, input logic [VW-1:0] b,
                                     input logic [TAG_W-1:0] tag, input int acc);
    exp_t   e;
    longint v;
    logic   o;
    e.llr = '0;
    e.ovf = '0;
    e.tag = tag;
    e.acc = acc;
    for (int i = 0; i < LANES; i++) begin
      lane_model(mode, u[i], lane_val(a, i), lane_val(b, i), v, o);
      e.llr[i*LLR_W +: LLR_W] = v[LLR_W-1:0];
      e.ovf[i]                = o;
    end
    return e;
  endfunction

  // Compare process: outputs are settled 2 time units after each falling edge.
  always begin : monitor
    exp_t e;
    logic exp_valid;
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("out_valid", longint'(out_valid), longint'(exp_valid));
      chk("busy", longint'(busy), longint'(q.size() > 0));
      chk("in_ready", longint'(in_ready), longint'(!(q.size() == 2 && !out_ready)));
      if (out_valid && exp_valid) begin
        e = q[0];
        n_checks++;
        if (out_llr === e.llr) n_pass++;
        else $display("FAIL out_llr: got %h, expected %h (t=%0t)", out_llr, e.llr, $time);
        chk("out_tag", longint'(out_tag), longint'(e.tag));
        chk("out_ovf", longint'(out_ovf), longint'(e.ovf));
        if (out_ready) begin
          seen_tags.push_back(out_tag);
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready)
        q.push_back(model_vec(in_mode, in_u, in_llr_a, in_llr_b, in_tag, cyc));
    end
  end

  function automatic logic [LLR_W-1:0] rand_llr();
    logic [LLR_W-1:0] x;
    longint           s;
    x = '0;
    x[LLR_W-1] = 1'b1;
    case ($urandom_range(0, 5))
      0: return x;
      1: return ~x;
      2: return x | LLR_W'(1);
      3: begin
        s = longint'($urandom_range(0, 40)) - 20;
        return s[LLR_W-1:0];
      end
      default: return LLR_W'($urandom);
    endcase
  endfunction

  task automatic rand_inputs();
    in_mode = 1'($urandom_range(0, 1));
    in_u    = LANES'($urandom);
    in_tag  = TAG_W'($urandom);
    for (int i = 0; i < LANES; i++) begin
      in_llr_a[i*LLR_W +: LLR_W] = rand_llr();
      in_llr_b[i*LLR_W +: LLR_W] = rand_llr();
    end
  endtask

  // Drains the pipeline and returns aligned to a falling edge.
  task automatic wait_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (!busy) break;
    end
    chk("drain_timeout", longint'(busy), 0);
    @(negedge clk);
  endtask

  task automatic directed(input string name, input logic mode, input logic [1:0] u,
                          input longint a0, input longint b0, input longint a1,
                          input longint b1, input longint e0, input longint e1,
                          input logic [1:0] eovf);
    logic [LANES-1:0] ev;
    wait_idle();
    in_valid = 1'b1;
    in_mode  = mode;
    in_u     = '0;
    in_u[1:0] = u;
    in_llr_a = '0;
    in_llr_b = '0;
    in_llr_a[0 +: LLR_W]     = lv(a0);
    in_llr_b[0 +: LLR_W]     = lv(b0);
    in_llr_a[LLR_W +: LLR_W] = lv(a1);
    in_llr_b[LLR_W +: LLR_W] = lv(b1);
    in_tag    = TAG_W'(42);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    ev = '0;
    ev[1:0] = eovf;
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_lane0"}, lane_val(out_llr, 0), e0);
    chk({name, "_lane1"}, lane_val(out_llr, 1), e1);
    chk({name, "_ovf"}, longint'(out_ovf), longint'(ev));
    chk({name, "_tag"}, longint'(out_tag), 42);
  endtask

  initial begin : stim
    int k;
    int t;
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_llr_a  = '0;
    in_llr_b  = '0;
    rand_inputs();

    // Reset held two cycles with in_valid high: nothing may come out.
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #3;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_llr_zero", longint'(out_llr != '0), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    repeat (3) @(negedge clk);
    #3;
    chk("rst_no_output", longint'(out_valid), 0);

    directed("f_basic", 1'b0, 2'b00, -20, 7, 5, 5, -7, 5, 2'b00);
    directed("g_basic", 1'b1, 2'b10, -20, 7, -20, 7, -13, 27, 2'b00);
`ifdef PE_SAT_EN
    directed("g_ovf", 1'b1, 2'b00, MAXV, MAXV, 0, 0, MAXV, 0, 2'b01);
    directed("f_min", 1'b0, 2'b00, MINV, MINV, 0, 0, MAXV, 0, 2'b01);
`else
    directed("g_ovf", 1'b1, 2'b00, MAXV, MAXV, 0, 0, -2, 0, 2'b01);
    directed("f_min", 1'b0, 2'b00, MINV, MINV, 0, 0, MINV, 0, 2'b01);
`endif

    // Backpressure: tags 0..5, out_ready low for 4 cycles mid-stream.
    wait_idle();
    seen_tags.delete();
    k = 0;
    t = 0;
    while (k < 6 && t < 40) begin
      in_valid  = 1'b1;
      rand_inputs();
      in_tag    = TAG_W'(k);
      out_ready = !(t >= 2 && t < 6);
      #1;
      if (t == 3) begin
        chk("bp_in_ready_low", longint'(in_ready), 0);
        chk("bp_hold_tag_early", longint'(out_tag), 0);
      end
      if (t == 5) chk("bp_hold_tag_late", longint'(out_tag), 0);
      if (in_ready) k++;
      @(negedge clk);
      t++;
    end
    chk("bp_sent", longint'(k), 6);
    wait_idle();
    chk("bp_count", longint'(seen_tags.size()), 6);
    for (int i = 0; i < 6 && i < seen_tags.size(); i++)
      chk("bp_order", longint'(seen_tags[i]), longint'(i));

    // Throughput: 16 back-to-back vectors.
    wait_idle();
    for (int j = 0; j < 16; j++) begin
      in_valid  = 1'b1;
      rand_inputs();
      in_tag    = TAG_W'(j);
      out_ready = 1'b1;
      #1;
      chk("tput_in_ready", longint'(in_ready), 1);
      #2;
      if (j >= 2) begin
        chk("tput_out_valid", longint'(out_valid), 1);
        chk("tput_out_tag", longint'(out_tag), longint'(j - 2));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #3;
    chk("tput_tail14", longint'(out_tag), 14);
    @(negedge clk);
    #3;
    chk("tput_tail15", longint'(out_tag), 15);
    chk("tput_busy_hi", longint'(busy), 1);
    @(negedge clk);
    #3;
    chk("tput_busy_lo", longint'(busy), 0);
    chk("tput_drained", longint'(out_valid), 0);

    // Reset during a full stall.
    wait_idle();
    out_ready = 1'b0;
    repeat (3) begin
      in_valid = 1'b1;
      rand_inputs();
      @(negedge clk);
    end
    #3;
    chk("stall_full", longint'(in_ready), 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #3;
    chk("mrst_out_valid", longint'(out_valid), 0);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_in_ready", longint'(in_ready), 1);
    chk("mrst_out_llr_zero", longint'(out_llr != '0), 0);
    chk("mrst_out_tag", longint'(out_tag), 0);
    chk("mrst_out_ovf", longint'(out_ovf), 0);
    out_ready = 1'b1;

    // Randomized traffic with random backpressure and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      rand_inputs();
      if ((n / 64) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
